cla_pipe_adder: RTL



---
 rtl/cla_pipe_adder.sv | 110 +++++++++++
 1 files changed

// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder: pipelined carry-lookahead adder/subtractor with valid/ready streaming
module cla_pipe_adder #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int STAGES = WIDTH / CHUNK;

    logic             adv;
    logic [WIDTH-1:0] lx, ly;
    logic [CHUNK:0]   lr;
    logic             lv;
    logic             ovf_r;

    // One CHUNK-bit slice: 4-bit lookahead groups, group carries ripple between groups.
    function automatic logic [CHUNK:0] cla(input logic [CHUNK-1:0] x, input logic [CHUNK-1:0] y, input logic ci);
        logic [CHUNK-1:0] g, p;
        logic [CHUNK:0]   c;
        g = x & y;
        p = x ^ y;
        c = '0;
        c[0] = ci;
        for (int k = 0; k < CHUNK; k += 4) begin
            c[k+1] = g[k] | (p[k] & c[k]);
            c[k+2] = g[k+1] | (p[k+1] & g[k]) | (p[k+1] & p[k] & c[k]);
            c[k+3] = g[k+2] | (p[k+2] & g[k+1]) | (p[k+2] & p[k+1] & g[k]) | (p[k+2] & p[k+1] & p[k] & c[k]);
            c[k+4] = g[k+3] | (p[k+3] & g[k+2]) | (p[k+3] & p[k+2] & g[k+1]) | (p[k+3] & p[k+2] & p[k+1] & g[k])
                   | (p[k+3] & p[k+2] & p[k+1] & p[k] & c[k]);
        end
        return {c[CHUNK], p ^ c[CHUNK-1:0]};
    endfunction

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    for (genvar j = 0; j < STAGES; j++) begin : g_stage
        // xq: resolved sum bits below the slice boundary, skewed operand A above it
        logic [WIDTH-1:0] xq, yq;
        logic             cq, zq, vq;
        logic [WIDTH-1:0] xin, yin;
        logic             cin_s, vin, zin;
        logic [CHUNK:0]   r;
        if (j == 0) begin : g_first
            assign xin   = a;
            assign yin   = sub ? ~b : b;
            assign cin_s = sub ? ~cin : cin;
            assign vin   = in_valid;
            assign zin   = 1'b1;
        end else begin : g_rest
            assign xin   = g_stage[j-1].xq;
            assign yin   = g_stage[j-1].yq;
            assign cin_s = g_stage[j-1].cq;
            assign vin   = g_stage[j-1].vq;
            assign zin   = g_stage[j-1].zq;
        end
        assign r = cla(xin[j*CHUNK +: CHUNK], yin[j*CHUNK +: CHUNK], cin_s);
        // Stage register: shifts on adv, data loads only for real beats so bubbles keep last values
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vq <= 1'b0;
                xq <= '0;
                yq <= '0;
                cq <= 1'b0;
                zq <= 1'b0;
            end else if (adv) begin
                vq <= vin;
                if (vin) begin
                    xq                   <= xin;
                    xq[j*CHUNK +: CHUNK] <= r[CHUNK-1:0];
                    yq                   <= yin;
                    cq                   <= r[CHUNK];
                    zq                   <= zin & ~|r[CHUNK-1:0];
                end
            end
        end
    end

    assign lx = g_stage[STAGES-1].xin;
    assign ly = g_stage[STAGES-1].yin;
    assign lr = g_stage[STAGES-1].r;
    assign lv = g_stage[STAGES-1].vin;

    // Overflow: carry into the MSB (recovered from its sum bit) XOR carry out of the MSB
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            ovf_r <= 1'b0;
        else if (adv && lv)
            ovf_r <= lx[WIDTH-1] ^ ly[WIDTH-1] ^ lr[CHUNK-1] ^ lr[CHUNK];
    end

    assign out_valid = g_stage[STAGES-1].vq;
    assign sum       = g_stage[STAGES-1].xq;
    assign cout      = g_stage[STAGES-1].cq;
    assign zero      = g_stage[STAGES-1].zq;
    assign ovf       = ovf_r;
endmodule
